dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

- Parametrised byte-addressed data memory with a request/response handshake and a configurable wait-state count.
- Supports byte, halfword and word accesses, little-endian.
- Loads are sign- or zero-extended; misaligned and out-of-range accesses are flagged.
- Sits between the pipeline's MEM stage and local storage, replacing the fixed 32-byte, word-only data memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DEPTH_BYTES, 1024, storage size in bytes; power of two, ≥4
- LATENCY, 1, cycles from acceptance to response; ≥1

Ports:
- clk_i  in  1  clock; all state changes on its rising edge
- rst_i  in  1  reset; synchronous, active-high
- req_i  in  1  access request
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  load extension: 1 = zero, 0 = sign
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data, low bytes used for byte/half
- ready_o  out  1  request can be accepted this cycle
- resp_o  out  1  one-cycle response pulse for every accepted access
- rdata_o  out  32  load result
- err_o  out  1  qualifies resp_o; access rejected

## Operation
- **Acceptance:** a request is accepted at a rising edge where `req_i && ready_o`. Address, size, we, unsigned and wdata are captured at that edge.
- **Error check** (evaluated at acceptance), err = 1 when any of:
  - size_i = 11
  - half with addr[0] ≠ 0
  - word with addr[1:0] ≠ 0
  - addr + nbytes > DEPTH_BYTES, with the sum computed at ADDR_W+1 bits (no wrap)
- **Store:** bytes are written at the acceptance edge, little-endian: byte n of wdata goes to addr+n. An erroring store writes nothing.
- **Load:** bytes are read at the acceptance edge, so a load sees every store accepted earlier.
  - Byte/half results are extended per unsigned_i.
  - An erroring load returns 0.
- **rdata_o:** updated only on resp_o cycles. It is 0 for stores and errors and holds between responses.
- **FSM states:** IDLE, WAIT.
  - IDLE → WAIT on acceptance when LATENCY > 1, with counter loaded to LATENCY−1.
  - WAIT decrements the counter. When the counter reaches 1, the next edge raises resp_o and returns to IDLE.
  - With LATENCY = 1, WAIT is never entered.
- **ready_o** = (state == IDLE). It is high during the resp_o cycle, allowing back-to-back accesses.
- **Memory contents** are not reset and are X until written.

## Timing
- **Reset values:** ready_o 1, resp_o 0, rdata_o 0, err_o 0, state IDLE, counter 0.
- **Latency:** acceptance at edge E → resp_o, rdata_o and err_o valid in the cycle following edge E+LATENCY−1.
- **Throughput:** one access per LATENCY cycles.
- resp_o is high for exactly one cycle per accepted access.
- req_i while ready_o = 0 is ignored; the requester holds it until accepted.
- **Reset mid-operation:** the pending response is dropped (no resp_o) and ready_o = 1 in the next cycle. A store already committed at acceptance stays committed.
- **Simultaneous reset and request:** reset wins; nothing is accepted and nothing is written.
- **Last-byte boundary:** a word at DEPTH_BYTES−4 is legal; a word at DEPTH_BYTES−4+4 errs.

## Structure
- **Package dmem_pkg:**
  - size encoding constants SZ_B, SZ_H, SZ_W
  - state enum (IDLE, WAIT)
  - function returning nbytes for a size
- **Sub-module dmem_align** (combinational):
  - store-side byte-enable and lane generation
  - load-side lane select plus sign/zero extension
- **Top dmem_ctrl:** byte array, FSM, latency counter, error check, output registers.

## Test plan
Bench parameters: DEPTH_BYTES = 64, LATENCY = 2 unless stated.
1. sw 0x08 ← 0xDEADBEEF, then lw 0x08 → rdata 0xDEADBEEF, err 0, resp_o two cycles after each acceptance, ready_o low for one cycle.
2. Loads from the data in scenario 1:
   - lb 0x08 signed → 0xFFFFFFEF
   - lbu 0x0B → 0x000000DE
   - lh 0x0A signed → 0xFFFFDEAD
   - lhu 0x08 → 0x0000BEEF
3. sh 0x09 ← 0x1234 → err 1, rdata 0; lw 0x08 still returns 0xDEADBEEF. size_i = 11 → err 1.
4. sw 0x3C ← 0x01020304 → err 0. lw 0x40 → err 1, rdata 0. lh 0x3F → err 1 (misaligned). Both erroring accesses (addresses 0x40, 0x3F) leave memory unchanged.
5. LATENCY = 1, req_i held high for three stores to 0x0/0x4/0x8 → three accepts on consecutive edges, three consecutive resp_o pulses, ready_o constantly 1.
6. lw accepted, rst_i high the next cycle → no resp_o ever for that load, ready_o 1, all outputs at reset values the cycle after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressed data memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Illegal size reports 4 bytes; it is rejected separately anyway.
    function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_nbytes = 3'd1;
            SZ_H:    size_nbytes = 3'd2;
            default: size_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the data memory.
interface dmem_if #(
    parameter int ADDR_W = 32
) ();

    logic              req_i;
    logic              we_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic              ready_o;
    logic              resp_o;
    logic [31:0]       rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  ready_o, resp_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output ready_o, resp_o, rdata_o, err_o
    );

endinterface

// File: rtl/dmem_align.sv
// Little-endian lane steering: store byte enables/lanes and load
// lane select with sign or zero extension.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = rword >> {offset, 3'b000};

    always_comb begin
        be     = '0;
        wlanes = '0;
        rdata  = '0;
        // Replicating the low data across lanes lets the enable pick the slot.
        case (size)
            SZ_B: begin
                be     = 4'b0001 << offset;
                wlanes = {4{wdata[7:0]}};
                rdata  = uns ? {24'b0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be     = 4'b0011 << offset;
                wlanes = {2{wdata[15:0]}};
                rdata  = uns ? {16'b0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                be     = 4'b1111;
                wlanes = wdata;
                rdata  = shifted;
            end
            default: begin
                be     = '0;
                wlanes = '0;
                rdata  = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with wait-state handshake; accesses are
// performed at acceptance and the response is delayed by LATENCY cycles.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    dmem_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [7:0]        mem [DEPTH_BYTES];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              resp_q, resp_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              pend_err_q, pend_err_d;
    logic [31:0]       pend_data_q, pend_data_d;

    logic              ready;
    logic              accept;
    logic              misaligned;
    logic [ADDR_W:0]   end_addr;
    logic              acc_err;
    logic [31:0]       acc_data;
    logic [IDX_W-1:0]  base;
    logic [31:0]       rd_word;
    logic [3:0]        be;
    logic [31:0]       wlanes;
    logic [31:0]       ld_data;

    assign ready  = (state_q == IDLE);
    assign accept = bus.req_i && ready && !rst_i;

    assign misaligned = ((bus.size_i == SZ_H) && bus.addr_i[0]) ||
                        ((bus.size_i == SZ_W) && (bus.addr_i[1:0] != 2'b00));
    // One extra bit so an access running past the top never wraps to legal.
    assign end_addr   = {1'b0, bus.addr_i} + (ADDR_W+1)'(size_nbytes(bus.size_i));
    assign acc_err    = (bus.size_i == SZ_X) || misaligned ||
                        (end_addr > (ADDR_W+1)'(DEPTH_BYTES));

    assign base    = bus.addr_i[IDX_W-1:0] & ~IDX_W'(3);
    assign rd_word = {mem[base | IDX_W'(3)], mem[base | IDX_W'(2)],
                      mem[base | IDX_W'(1)], mem[base]};

    dmem_align u_align (
        .size   (bus.size_i),
        .offset (bus.addr_i[1:0]),
        .uns    (bus.unsigned_i),
        .wdata  (bus.wdata_i),
        .rword  (rd_word),
        .be     (be),
        .wlanes (wlanes),
        .rdata  (ld_data)
    );

    assign acc_data = (acc_err || bus.we_i) ? '0 : ld_data;

    always_ff @(posedge clk_i) begin
        if (accept && bus.we_i && !acc_err) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (be[n]) begin
                    mem[base | IDX_W'(n)] <= wlanes[8*n +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_err_d  = pend_err_q;
        pend_data_d = pend_data_q;
        resp_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        resp_d  = 1'b1;
                        err_d   = acc_err;
                        rdata_d = acc_data;
                    end else begin
                        state_d     = WAIT;
                        cnt_d       = CNT_W'(LATENCY - 1);
                        pend_err_d  = acc_err;
                        pend_data_d = acc_data;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    resp_d  = 1'b1;
                    err_d   = pend_err_q;
                    rdata_d = pend_data_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            resp_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            pend_err_q  <= 1'b0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            pend_err_q  <= pend_err_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign bus.ready_o = ready;
    assign bus.resp_o  = resp_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (LATENCY 2 and 1) checked against a
// byte-array reference model with randomized and directed accesses.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 64;
    localparam int L2    = 2;
    localparam int L1    = 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req, we, uns, solo1;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mm [DEPTH];

    always #5 clk_i = ~clk_i;

    dmem_if #(.ADDR_W(32)) bus2 ();
    dmem_if #(.ADDR_W(32)) bus1 ();

    assign bus2.req_i      = req && !solo1;
    assign bus2.we_i       = we;
    assign bus2.size_i     = sz;
    assign bus2.unsigned_i = uns;
    assign bus2.addr_i     = addr;
    assign bus2.wdata_i    = wdata;
    assign bus1.req_i      = req;
    assign bus1.we_i       = we;
    assign bus1.size_i     = sz;
    assign bus1.unsigned_i = uns;
    assign bus1.addr_i     = addr;
    assign bus1.wdata_i    = wdata;

    dmem_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .LATENCY(L2)) dut2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus2)
    );

    dmem_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .LATENCY(L1)) dut1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_access(input logic w, input logic [1:0] s, input logic u,
                                         input logic [31:0] a, input logic [31:0] d,
                                         output logic [31:0] rd, output logic e);
        int unsigned     nb;
        longint unsigned v;
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
        e  = 1'b0;
        if (nb == 0)                              e = 1'b1;
        else if ((a % nb) != 0)                   e = 1'b1;
        else if (longint'(a) + nb > longint'(DEPTH)) e = 1'b1;
        rd = '0;
        if (!e) begin
            if (w) begin
                for (int unsigned i = 0; i < nb; i++)
                    mm[a + i] = 8'((d >> (8 * i)) & 32'hFF);
            end else begin
                v = 0;
                for (int unsigned i = 0; i < nb; i++)
                    v = v | (longint'(mm[a + i]) << (8 * i));
                if (!u && nb < 4 && v[8*nb-1])
                    v = v | ~((64'd1 << (8 * nb)) - 1);
                rd = v[31:0];
            end
        end
    endfunction

    // One access on both instances; checks latency, pulse count, data and error.
    task automatic access(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          input string tag, output logic [31:0] got);
        logic [31:0] er, d1, d2;
        logic        ee, e1, e2;
        int          r1, r2, n1, n2;
        @(negedge clk_i);
        check({tag, " ready"}, 32'({bus1.ready_o, bus2.ready_o}), 32'b11);
        req = 1'b1; we = w; sz = s; uns = u; addr = a; wdata = d;
        @(posedge clk_i);
        #1;
        req = 1'b0;
        model_access(w, s, u, a, d, er, ee);
        n1 = 0; n2 = 0; r1 = -1; r2 = -1;
        d1 = 'x; d2 = 'x; e1 = 1'bx; e2 = 1'bx;
        for (int k = 0; k < 6; k++) begin
            if (k == 0)
                check({tag, " busy"}, 32'({bus1.ready_o, bus2.ready_o}), 32'b10);
            if (bus1.resp_o) begin n1++; r1 = k; d1 = bus1.rdata_o; e1 = bus1.err_o; end
            if (bus2.resp_o) begin n2++; r2 = k; d2 = bus2.rdata_o; e2 = bus2.err_o; end
            if (k < 5) begin
                @(posedge clk_i);
                #1;
            end
        end
        check({tag, " lat1"},   32'(r1), 32'(L1 - 1));
        check({tag, " npulse1"}, 32'(n1), 32'd1);
        check({tag, " rdata1"}, d1, er);
        check({tag, " err1"},   32'(e1), 32'(ee));
        check({tag, " lat2"},   32'(r2), 32'(L2 - 1));
        check({tag, " npulse2"}, 32'(n2), 32'd1);
        check({tag, " rdata2"}, d2, er);
        check({tag, " err2"},   32'(e2), 32'(ee));
        check({tag, " hold2"},  bus2.rdata_o, er);
        got = d2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, a;
        logic [1:0]  s;
        int          seen;

        rst_i = 1'b1; req = 1'b0; we = 1'b0; uns = 1'b0; solo1 = 1'b0;
        sz = SZ_W; addr = '0; wdata = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst ready", 32'({bus1.ready_o, bus2.ready_o}), 32'b11);
        check("rst resp",  32'({bus1.resp_o, bus2.resp_o}), 32'b0);
        check("rst err",   32'({bus1.err_o, bus2.err_o}), 32'b0);
        check("rst rdata2", bus2.rdata_o, 32'h0);
        check("rst rdata1", bus1.rdata_o, 32'h0);
        rst_i = 1'b0;

        for (int w = 0; w < DEPTH / 4; w++)
            access(1'b1, SZ_W, 1'b0, 32'(w * 4), $urandom, "fill", got);

        access(1'b1, SZ_W, 1'b0, 32'h08, 32'hDEADBEEF, "sw08", got);
        check("sw08 rdata", got, 32'h0);
        access(1'b0, SZ_W, 1'b0, 32'h08, 32'h0, "lw08", got);
        check("lw08 const", got, 32'hDEADBEEF);

        access(1'b0, SZ_B, 1'b0, 32'h08, 32'h0, "lb08", got);
        check("lb08 const", got, 32'hFFFFFFEF);
        access(1'b0, SZ_B, 1'b1, 32'h0B, 32'h0, "lbu0b", got);
        check("lbu0b const", got, 32'h000000DE);
        access(1'b0, SZ_H, 1'b0, 32'h0A, 32'h0, "lh0a", got);
        check("lh0a const", got, 32'hFFFFDEAD);
        access(1'b0, SZ_H, 1'b1, 32'h08, 32'h0, "lhu08", got);
        check("lhu08 const", got, 32'h0000BEEF);

        access(1'b1, SZ_H, 1'b0, 32'h09, 32'h1234, "sh09", got);
        check("sh09 rdata", got, 32'h0);
        access(1'b0, SZ_W, 1'b0, 32'h08, 32'h0, "lw08b", got);
        check("lw08b const", got, 32'hDEADBEEF);
        access(1'b0, SZ_X, 1'b0, 32'h08, 32'h0, "size11", got);

        access(1'b1, SZ_W, 1'b0, 32'h3C, 32'h01020304, "sw3c", got);
        access(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, "lw40", got);
        access(1'b0, SZ_H, 1'b0, 32'h3F, 32'h0, "lh3f", got);
        access(1'b1, SZ_W, 1'b0, 32'h40, 32'hFFFFFFFF, "sw40", got);
        access(1'b1, SZ_H, 1'b0, 32'h3F, 32'hFFFF, "sh3f", got);
        access(1'b1, SZ_B, 1'b0, 32'h40, 32'hFF, "sb40", got);
        access(1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, "lw3c", got);
        check("lw3c const", got, 32'h01020304);
        access(1'b0, SZ_B, 1'b1, 32'h3F, 32'h0, "lbu3f", got);
        check("lbu3f const", got, 32'h00000001);

        // Request coinciding with reset must not commit.
        @(negedge clk_i);
        rst_i = 1'b1; req = 1'b1; we = 1'b1; sz = SZ_W; addr = 32'h10; wdata = 32'hCAFEF00D;
        @(posedge clk_i);
        #1;
        req = 1'b0; rst_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            seen = seen | int'(bus1.resp_o) | int'(bus2.resp_o);
            @(posedge clk_i);
            #1;
        end
        check("rstreq noresp", 32'(seen), 32'd0);
        access(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "rstreq lw10", got);

        for (int i = 0; i < 200; i++) begin
            s = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, DEPTH + 7));
            if ($urandom_range(0, 1) == 1 && s != SZ_X)
                a = a & ~((32'd1 << s) - 32'd1);
            access(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom,
                   "rand", got);
        end

        // Back-to-back stores on the single-cycle instance only.
        @(negedge clk_i);
        solo1 = 1'b1;
        req = 1'b1; we = 1'b1; sz = SZ_W; uns = 1'b0; addr = 32'h0; wdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("b2b ready1", 32'(bus1.ready_o), 32'd1);
            check("b2b resp1",  32'(bus1.resp_o), 32'd1);
            check("b2b err1",   32'(bus1.err_o), 32'd0);
            check("b2b resp2",  32'(bus2.resp_o), 32'd0);
            addr = 32'((i + 1) * 4); wdata = $urandom;
        end
        req = 1'b0;
        @(posedge clk_i);
        #1;
        check("b2b end resp1", 32'(bus1.resp_o), 32'd0);
        solo1 = 1'b0;
        for (int w = 0; w < 3; w++)
            access(1'b1, SZ_W, 1'b0, 32'(w * 4), $urandom, "resync", got);
        access(1'b0, SZ_W, 1'b0, 32'h4, 32'h0, "resync lw4", got);

        // Reset one cycle after a load is accepted drops its response.
        @(negedge clk_i);
        req = 1'b1; we = 1'b0; sz = SZ_W; addr = 32'h08;
        @(posedge clk_i);
        #1;
        req = 1'b0; rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("midrst ready", 32'({bus1.ready_o, bus2.ready_o}), 32'b11);
        check("midrst resp",  32'({bus1.resp_o, bus2.resp_o}), 32'b0);
        check("midrst err",   32'({bus1.err_o, bus2.err_o}), 32'b0);
        check("midrst rdata2", bus2.rdata_o, 32'h0);
        check("midrst rdata1", bus1.rdata_o, 32'h0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #1;
            seen = seen | int'(bus2.resp_o);
        end
        check("midrst noresp2", 32'(seen), 32'd0);
        access(1'b0, SZ_W, 1'b0, 32'h08, 32'h0, "postrst lw08", got);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
